// File: rtl/pipe_controller_pkg.sv
// Shared playfield constants and helpers for the pipe controller and the collision detector.
package pipe_controller_pkg;

  typedef logic [10:0] coord_t;

  localparam coord_t SCREEN_WIDTH    = 11'd640;
  localparam coord_t SCREEN_HEIGHT   = 11'd480;
  localparam coord_t PIPE_WIDTH      = 11'd20;
  localparam coord_t PIPE_HEIGHT_GAP = 11'd50;
  localparam coord_t BIRD_X          = 11'd160;
  localparam coord_t GAP_MIN         = 11'd100;
  localparam coord_t PIPE_START_X    = 11'd660;
  localparam coord_t PIPE_START_Y    = 11'd240;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [9:0]  SCORE_MAX = 10'd999;

  // Gap centre drawn from the low LFSR byte: 100..355.
  function automatic coord_t gap_y(input logic [15:0] r);
    return GAP_MIN + coord_t'(r[7:0]);
  endfunction

  function automatic logic [9:0] score_add(input logic [9:0] s, input logic [1:0] inc);
    logic [10:0] sum;
    sum = {1'b0, s} + {9'b0, inc};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
  endfunction

endpackage

// File: rtl/pipe_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for pipe gap heights.
module lfsr16
  import pipe_controller_pkg::*;
(
  input  logic        gameClk,
  input  logic        reset,
  output logic [15:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipe scroller: IDLE/RUN/HIT control, pipe x/y update with wrap, and saturating score.
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_SPACING = 320,
  parameter int GRACE        = 2
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        start,
  input  logic        hitColumn,
  output logic [10:0] Ax,
  output logic [10:0] Bx,
  output logic [10:0] Ay,
  output logic [10:0] By,
  output logic        running,
  output logic [9:0]  score
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  localparam int     GW      = (GRACE > 1) ? $clog2(GRACE + 1) : 1;
  localparam coord_t SPEED   = coord_t'(PIPE_SPEED);
  localparam coord_t SPACING = coord_t'(PIPE_SPACING);
  localparam coord_t B_START = PIPE_START_X + SPACING;

  logic [1:0]    state;
  logic [GW-1:0] grace;
  logic [15:0]   lfsr_q;

  coord_t a_dec, b_dec, a_next, b_next;
  logic   a_wrap, b_wrap, a_cross, b_cross, hit_now, load;

  lfsr16 u_lfsr (
    .gameClk (gameClk),
    .reset   (reset),
    .q       (lfsr_q)
  );

  // Wrap is decided on the current x, so a wrapping pipe never subtracts past zero.
  assign a_dec   = Ax - SPEED;
  assign b_dec   = Bx - SPEED;
  assign a_wrap  = (Ax <= PIPE_WIDTH);
  assign b_wrap  = (Bx <= PIPE_WIDTH);
  assign a_next  = a_wrap ? b_dec + SPACING : a_dec;
  assign b_next  = b_wrap ? a_dec + SPACING : b_dec;
  assign a_cross = (Ax >= BIRD_X) && (a_next < BIRD_X);
  assign b_cross = (Bx >= BIRD_X) && (b_next < BIRD_X);

  assign load    = start && (state != S_RUN);
  assign hit_now = hitColumn && (grace == '0);

  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      running <= 1'b0;
      Ax      <= PIPE_START_X;
      Bx      <= B_START;
      Ay      <= PIPE_START_Y;
      By      <= PIPE_START_Y;
      score   <= '0;
      grace   <= '0;
    end else if (load) begin
      state   <= S_RUN;
      running <= 1'b1;
      Ax      <= PIPE_START_X;
      Bx      <= B_START;
      Ay      <= PIPE_START_Y;
      By      <= PIPE_START_Y;
      score   <= '0;
      grace   <= GW'(GRACE);
    end else if (state == S_RUN) begin
      if (hit_now) begin
        // A collision freezes the whole frame; nothing else in RUN happens this edge.
        state   <= S_HIT;
        running <= 1'b0;
      end else begin
        if (grace != '0) grace <= grace - GW'(1);
        Ax    <= a_next;
        Bx    <= b_next;
        if (a_wrap) Ay <= gap_y(lfsr_q);
        if (b_wrap) By <= gap_y(lfsr_q);
        score <= score_add(score, {1'b0, a_cross} + {1'b0, b_cross});
      end
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Randomized bench for pipe_controller against a plain-arithmetic game model.
module tb_pipe_controller;

  typedef enum {M_IDLE, M_RUN, M_HIT} mode_t;
  typedef struct {
    mode_t       mode;
    int          ax, bx, ay, by, score, grace;
    int unsigned lfsr;
  } mstate_t;

  localparam int GRACE_CYC = 2;

  logic gameClk = 1'b0;
  always #5 gameClk = ~gameClk;

  int n_vec = 0;
  int n_bad = 0;

  // main instance (defaults)
  logic reset, start, hit_column;
  logic [10:0] ax, bx, ay, by;
  logic running;
  logic [9:0] score;
  logic [54:0] obs0;
  assign obs0 = {ax, bx, ay, by, running, score};

  // fast instance: reaches score saturation in a few thousand cycles
  logic reset_f, start_f, hit_f;
  logic [10:0] ax_f, bx_f, ay_f, by_f;
  logic running_f;
  logic [9:0] score_f;
  logic [54:0] obs_f;
  assign obs_f = {ax_f, bx_f, ay_f, by_f, running_f, score_f};

  // paired instance: both pipes coincide, so they cross the bird together
  logic reset_p, start_p, hit_p;
  logic [10:0] ax_p, bx_p, ay_p, by_p;
  logic running_p;
  logic [9:0] score_p;
  logic [54:0] obs_p;
  assign obs_p = {ax_p, bx_p, ay_p, by_p, running_p, score_p};

  pipe_controller dut (
    .gameClk(gameClk), .reset(reset), .start(start), .hitColumn(hit_column),
    .Ax(ax), .Bx(bx), .Ay(ay), .By(by), .running(running), .score(score));

  pipe_controller #(.PIPE_SPEED(80), .PIPE_SPACING(320), .GRACE(2)) dut_fast (
    .gameClk(gameClk), .reset(reset_f), .start(start_f), .hitColumn(hit_f),
    .Ax(ax_f), .Bx(bx_f), .Ay(ay_f), .By(by_f), .running(running_f), .score(score_f));

  pipe_controller #(.PIPE_SPEED(2), .PIPE_SPACING(0), .GRACE(2)) dut_pair (
    .gameClk(gameClk), .reset(reset_p), .start(start_p), .hitColumn(hit_p),
    .Ax(ax_p), .Bx(bx_p), .Ay(ay_p), .By(by_p), .running(running_p), .score(score_p));

  // ---------------- reference model ----------------
  function automatic int wrap11(int v);
    return ((v % 2048) + 2048) % 2048;
  endfunction

  function automatic mstate_t model_reset(int spacing);
    mstate_t m;
    m.mode = M_IDLE; m.ax = 660; m.bx = wrap11(660 + spacing);
    m.ay = 240; m.by = 240; m.score = 0; m.grace = 0; m.lfsr = 32'hACE1;
    return m;
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit st, bit hit, int speed, int spacing);
    mstate_t n;
    int fb, a_new, b_new, crossed;
    n = s;
    // taps 16,14,13,11 sit at bit positions 0,2,3,5 of a right-shifting register
    fb = int'((s.lfsr ^ (s.lfsr >> 2) ^ (s.lfsr >> 3) ^ (s.lfsr >> 5)) & 1);
    n.lfsr = (s.lfsr >> 1) | (fb << 15);
    if (s.mode != M_RUN) begin
      if (st) begin
        n.mode = M_RUN; n.ax = 660; n.bx = wrap11(660 + spacing);
        n.ay = 240; n.by = 240; n.score = 0; n.grace = GRACE_CYC;
      end
    end else if (hit && s.grace == 0) begin
      n.mode = M_HIT;
    end else begin
      if (s.grace > 0) n.grace = s.grace - 1;
      a_new = (s.ax <= 20) ? wrap11(s.bx - speed + spacing) : wrap11(s.ax - speed);
      b_new = (s.bx <= 20) ? wrap11(s.ax - speed + spacing) : wrap11(s.bx - speed);
      if (s.ax <= 20) n.ay = 100 + int'(s.lfsr & 255);
      if (s.bx <= 20) n.by = 100 + int'(s.lfsr & 255);
      crossed = int'(s.ax >= 160 && a_new < 160) + int'(s.bx >= 160 && b_new < 160);
      n.score = (s.score + crossed > 999) ? 999 : s.score + crossed;
      n.ax = a_new; n.bx = b_new;
    end
    return n;
  endfunction

  function automatic logic [54:0] pack(mstate_t m);
    return {11'(m.ax), 11'(m.bx), 11'(m.ay), 11'(m.by), m.mode == M_RUN, 10'(m.score)};
  endfunction

  mstate_t m_main, m_fast, m_pair;

  always @(posedge gameClk or posedge reset)
    if (reset) m_main = model_reset(320);
    else       m_main = model_step(m_main, start, hit_column, 2, 320);

  always @(posedge gameClk or posedge reset_f)
    if (reset_f) m_fast = model_reset(320);
    else         m_fast = model_step(m_fast, start_f, hit_f, 80, 320);

  always @(posedge gameClk or posedge reset_p)
    if (reset_p) m_pair = model_reset(0);
    else         m_pair = model_step(m_pair, start_p, hit_p, 2, 0);

  localparam logic [54:0] RESET_VEC = {11'd660, 11'd980, 11'd240, 11'd240, 1'b0, 10'd0};

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hit_column = 1'b0;
    repeat (3) @(negedge gameClk);
    n_vec++;
    if (obs0 !== RESET_VEC) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs0, RESET_VEC);
    end
    reset = 1'b0;
    hit_column = 1'b1;   // ignored while idle
    repeat (3) begin
      @(negedge gameClk);
      n_vec++;
      if (obs0 !== pack(m_main) || running !== 1'b0) begin
        n_bad++; $display("FAIL idle_hold: got %h want %h", obs0, pack(m_main));
      end
    end
    hit_column = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    @(negedge gameClk);
    start = 1'b0;
    n_vec++;
    if (running !== 1'b1 || ax !== 11'd660 || bx !== 11'd980) begin
      n_bad++; $display("FAIL start_load: got run=%b Ax=%0d Bx=%0d want run=1 Ax=660 Bx=980", running, ax, bx);
    end
    repeat (10) @(negedge gameClk);
    n_vec++;
    if (ax !== 11'd640 || bx !== 11'd960 || obs0 !== pack(m_main)) begin
      n_bad++; $display("FAIL move_10: got Ax=%0d Bx=%0d want Ax=640 Bx=960", ax, bx);
    end
  endtask

  task automatic test_wrap_and_score();
    mstate_t pre;
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      start = 1'($urandom_range(0, 1));   // restart requests are ignored mid-run
      pre = m_main;
      @(negedge gameClk);
      n_vec++;
      if (obs0 !== pack(m_main)) begin
        n_bad++; $display("FAIL run_step: got %h want %h", obs0, pack(m_main));
      end
      if (pre.ax == 160) begin
        n_vec++;
        if (score !== 10'(pre.score + 1)) begin
          n_bad++; $display("FAIL score_cross: got %0d want %0d", score, pre.score + 1);
        end
      end
      if (pre.ax == 20) begin
        done = 1;
        n_vec++;
        if (ax !== 11'(pre.bx - 2 + 320) || ay !== 11'(100 + (pre.lfsr & 255)) || ay < 100 || ay > 355) begin
          n_bad++; $display("FAIL wrap_a: got Ax=%0d Ay=%0d want Ax=%0d Ay=%0d",
                            ax, ay, pre.bx - 2 + 320, 100 + (pre.lfsr & 255));
        end
      end
    end
    start = 1'b0;
    if (!done) begin
      n_vec++; n_bad++; $display("FAIL wrap_timeout: got no wrap want wrap within 400 cycles");
    end
  endtask

  task automatic test_hit_freeze();
    logic [53:0] snap;
    hit_column = 1'b1;
    @(negedge gameClk);
    n_vec++;
    if (running !== 1'b0 || obs0 !== pack(m_main)) begin
      n_bad++; $display("FAIL hit_enter: got %h want %h", obs0, pack(m_main));
    end
    snap = {ax, bx, ay, by, score};
    repeat (20) begin
      hit_column = 1'($urandom_range(0, 1));
      @(negedge gameClk);
      n_vec++;
      if ({ax, bx, ay, by, score} !== snap || running !== 1'b0) begin
        n_bad++; $display("FAIL hit_frozen: got %h want %h", {ax, bx, ay, by, score}, snap);
      end
    end
  endtask

  task automatic test_restart_grace();
    hit_column = 1'b1;
    start = 1'b1;
    @(negedge gameClk);
    start = 1'b0;
    n_vec++;
    if (running !== 1'b1 || ax !== 11'd660 || bx !== 11'd980 || ay !== 11'd240 || score !== 10'd0) begin
      n_bad++; $display("FAIL restart_load: got run=%b Ax=%0d Bx=%0d Ay=%0d score=%0d", running, ax, bx, ay, score);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge gameClk);
      n_vec++;
      if (running !== (k < 3) || obs0 !== pack(m_main)) begin
        n_bad++; $display("FAIL grace_cycle%0d: got run=%b want run=%b", k, running, k < 3);
      end
    end
    hit_column = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      hit_column = ($urandom_range(0, 63) == 0);
      start      = ($urandom_range(0, 15) == 0);
      @(negedge gameClk);
      n_vec++;
      if (obs0 !== pack(m_main)) begin
        n_bad++; $display("FAIL random_step%0d: got %h want %h", c, obs0, pack(m_main));
      end
    end
    hit_column = 1'b0; start = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(negedge gameClk);
    start = 1'b0;
    repeat (5) @(negedge gameClk);
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_run: got run=%b want 1", running);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (obs0 !== RESET_VEC) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", obs0, RESET_VEC);
    end
    @(negedge gameClk);
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    bit saw_998 = 0;
    int after = -1;
    reset_f = 1'b0;
    start_f = 1'b1;
    @(negedge gameClk);
    start_f = 1'b0;
    for (int c = 0; c < 6000 && after != 0; c++) begin
      @(negedge gameClk);
      n_vec++;
      if (obs_f !== pack(m_fast)) begin
        n_bad++; $display("FAIL fast_step: got %h want %h", obs_f, pack(m_fast));
      end
      if (m_fast.score == 998 && !saw_998) saw_998 = 1;
      if (m_fast.score == 999 && after < 0) after = 40;
      else if (after > 0) after--;
    end
    n_vec++;
    if (!saw_998 || after != 0 || score_f !== 10'd999) begin
      n_bad++; $display("FAIL score_saturate: got %0d want 999 (saw998=%0d)", score_f, saw_998);
    end
    reset_f = 1'b1;
  endtask

  task automatic test_pair_cross();
    mstate_t pre;
    bit done = 0;
    reset_p = 1'b0;
    start_p = 1'b1;
    @(negedge gameClk);
    start_p = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      pre = m_pair;
      @(negedge gameClk);
      n_vec++;
      if (obs_p !== pack(m_pair)) begin
        n_bad++; $display("FAIL pair_step: got %h want %h", obs_p, pack(m_pair));
      end
      if (pre.ax == 160) begin
        done = 1;
        n_vec++;
        if (score_p !== 10'd2) begin
          n_bad++; $display("FAIL double_cross: got %0d want 2", score_p);
        end
      end
    end
    if (!done) begin
      n_vec++; n_bad++; $display("FAIL pair_timeout: got no crossing want one within 300 cycles");
    end
    reset_p = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hit_column = 1'b0;
    reset_f = 1'b1; start_f = 1'b0; hit_f = 1'b0;
    reset_p = 1'b1; start_p = 1'b0; hit_p = 1'b0;
    test_reset();
    test_start();
    test_wrap_and_score();
    test_hit_freeze();
    test_restart_grace();
    test_random();
    test_async_reset();
    test_saturate();
    test_pair_cross();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter PIPE_SPEED, default 2, pixels both pipes move left per RUN cycle.
REQ-002 Parameter PIPE_SPACING, default 320, horizontal distance between pipe A and pipe B centres.
REQ-003 Parameter GRACE, default 2, number of RUN-entry cycles during which hitColumn is ignored.
REQ-004 Clock and reset: gameClk is the clock; reset is asynchronous and active-high.
REQ-005 gameClk  in  1  game tick clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  level sampled each cycle; starts or restarts a run.
REQ-008 hitColumn  in  1  collision flag from the collision detector.
REQ-009 Ax, Bx  out  11  pipe A/B centre x, unsigned pixels.
REQ-010 Ay, By  out  11  pipe A/B gap centre y, unsigned pixels.
REQ-011 running  out  1  high in RUN only.
REQ-012 score  out  10  pipes passed, saturating at 999.

Function
REQ-013 FSM states SHALL be IDLE, RUN and HIT, with all outputs registered.
REQ-014 IDLE transitions to RUN when start=1; hitColumn is ignored in IDLE.
REQ-015 Entering RUN from IDLE or HIT SHALL load Ax=660, Bx=660+PIPE_SPACING=980, Ay=By=240, score=0 and grace counter=GRACE on the same edge.
REQ-016 Each RUN cycle, Ax and Bx SHALL each decrease by PIPE_SPEED.
REQ-017 RUN transitions to HIT on hitColumn=1 once the grace counter is 0; hitColumn SHALL have priority over every other RUN action in that cycle.
REQ-018 The grace counter SHALL decrement once per RUN cycle until it reaches 0; hitColumn is masked while the counter is non-zero.
REQ-019 Wrap: if the current x <= pipe_width (20), that pipe's x SHALL reload to the other pipe's next x + PIPE_SPACING, and its y SHALL reload to gap_min (100) + lfsr[7:0], giving a y range of 100..355.
REQ-020 Wrap of A and B in the same cycle is unreachable for legal parameters (PIPE_SPACING > 2*pipe_width); no priority rule is required.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in all states, never all-zero.
REQ-022 Scoring: score SHALL increment when a pipe's current x >= bird_x (160) and its next x < bird_x.
REQ-023 Scoring: A and B crossing bird_x in the same cycle SHALL add 2, saturating at 999.
REQ-024 HIT: Ax, Bx, Ay, By and score SHALL be frozen, running=0, and the LFSR SHALL keep running.
REQ-025 HIT transitions to RUN on start=1, reinitialising per REQ-015; start wins over a still-high hitColumn.
REQ-026 RUN with start=1 has no effect; there is no restart mid-run.
REQ-027 All arithmetic SHALL be 11-bit unsigned; the wrap check occurs before subtraction, so x never underflows.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, Ax=660, Bx=980, Ay=By=240, score=0, running=0, grace=0 and lfsr=16'hACE1.
REQ-029 Reset asserted mid-RUN or mid-HIT SHALL abandon the run with no partial score retained.

Structure
REQ-030 The shared constants include SHALL hold screen_width 640, screen_height 480, pipe_width 20, pipe_height_gap 50, bird_x 160, gap_min 100, pipe_start_x 660 and the LFSR seed.
REQ-031 The shared constants include SHALL be the same one the collision detector uses.
REQ-032 The LFSR SHALL be a sub-module, lfsr16 (ports: gameClk, reset, q[15:0]).
REQ-033 The FSM, position update and score logic SHALL reside in pipe_controller.

Verification
REQ-034 Reset, then start=1 for 1 cycle -> running=1 next edge; Ax=660, Bx=980; after 10 cycles Ax=640, Bx=960.
REQ-035 Run until Ax=20 -> next edge Ax=(Bx-2)+320; Ay lies in 100..355 and equals 100+lfsr[7:0] sampled at that edge.
REQ-036 Ax goes 160 -> 158 -> score increments by 1 on that edge; force score=998 and cross both pipes together -> score=999.
REQ-037 hitColumn=1 at grace=0 in RUN -> HIT next edge; positions are unchanged for 20 cycles while hitColumn toggles.
REQ-038 In HIT, hold hitColumn=1 and pulse start -> RUN with positions reinitialised; the run stays in RUN for 2 cycles despite hitColumn=1, then enters HIT on the 3rd.
REQ-039 Assert reset asynchronously mid-RUN between clock edges -> outputs reach their reset values before the next gameClk edge.
